// File: rtl/temporizador_nota.sv
// temporizador_nota: note duration timer with square-wave tone generator, responder side of the note controller.
module temporizador_nota #(
  parameter int W        = 28,
  parameter int MIN_HALF = 1
) (
  input  logic         Clk_in,
  input  logic         Rst_in,
  input  logic [W-1:0] Temp_in,
  input  logic [W-1:0] Freq_in,
  input  logic         Disparo_in,
  input  logic         Stop_in,
  output logic         Duracao,
  output logic         Audio_out
);
  typedef enum logic [1:0] {IDLE, RUN, FIM} state_t;
  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] HMIN = W'(MIN_HALF);
  state_t state, nxt;
  logic [W-1:0] dur_cnt, tone_cnt, f_q, half, half_m1, temp_ld;
  logic arm, aud_q, entering;
  always_comb begin
    arm      = Disparo_in && !Stop_in;
    half     = (Freq_in >> 1) < HMIN ? HMIN : Freq_in >> 1;
    half_m1  = half - ONE;
    temp_ld  = Temp_in == '0 ? '0 : Temp_in - ONE;
    entering = nxt == RUN && state != RUN;
  end
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = arm ? RUN : IDLE;
      RUN:     nxt = Stop_in ? IDLE : (dur_cnt == '0 ? FIM : RUN);
      FIM:     nxt = arm ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      tone_cnt <= '0;
      f_q      <= '0;
      aud_q    <= 1'b0;
    end else begin
      state <= nxt;
      f_q   <= Freq_in;
      if (entering)
        dur_cnt <= temp_ld;
      else if (state == RUN && dur_cnt != '0)
        dur_cnt <= dur_cnt - ONE;
      // tone is silent whenever the next cycle is not a running note
      if (nxt != RUN || Freq_in == '0) begin
        aud_q    <= 1'b0;
        tone_cnt <= '0;
      end else if (entering || f_q != Freq_in) begin
        aud_q    <= 1'b0;
        tone_cnt <= half_m1;
      end else if (tone_cnt == '0) begin
        aud_q    <= ~aud_q;
        tone_cnt <= half_m1;
      end else begin
        tone_cnt <= tone_cnt - ONE;
      end
    end
  end
  always_comb begin
    Duracao   = state == RUN;
    Audio_out = aud_q;
  end
endmodule

// File: tb/tb_temporizador_nota.sv
// tb_temporizador_nota: vector table plus hand sequences, expected outputs queued per edge and checked after it.
module tb_temporizador_nota;
  localparam int W = 28;
  logic         Clk_in = 1'b0;
  logic         Rst_in = 1'b0;
  logic [W-1:0] Temp_in = '0;
  logic [W-1:0] Freq_in = '0;
  logic         Disparo_in = 1'b0;
  logic         Stop_in = 1'b0;
  logic         Duracao, Audio_out;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic rst, disp, stop;
    int   temp, freq;
    logic d, a;
  } vec_t;
  vec_t tbl[$];
  logic [1:0] sb[$];

  temporizador_nota #(.W(W), .MIN_HALF(1)) dut (
    .Clk_in(Clk_in), .Rst_in(Rst_in), .Temp_in(Temp_in), .Freq_in(Freq_in),
    .Disparo_in(Disparo_in), .Stop_in(Stop_in), .Duracao(Duracao), .Audio_out(Audio_out)
  );

  always #5 Clk_in = ~Clk_in;

  task automatic step(input string name, input logic rst, input logic disp, input logic stop,
                      input int temp, input int freq, input logic d, input logic a);
    logic [1:0] exp_v;
    Rst_in     = rst;
    Disparo_in = disp;
    Stop_in    = stop;
    Temp_in    = W'(temp);
    Freq_in    = W'(freq);
    sb.push_back({d, a});
    @(posedge Clk_in);
    #1;
    exp_v = sb.pop_front();
    n_cmp++;
    if ({Duracao, Audio_out} !== exp_v) begin
      n_bad++;
      $display("FAIL %s @%0t: dur/aud got %b required %b", name, $time, {Duracao, Audio_out}, exp_v);
    end
  endtask

  task automatic add(input vec_t v, input int n);
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  initial begin
    add('{1, 0, 0, 0, 0, 0, 0}, 2);
    add('{0, 0, 0, 0, 0, 0, 0}, 2);
    add('{0, 1, 0, 5, 0, 1, 0}, 1);
    add('{0, 0, 0, 5, 0, 1, 0}, 4);
    add('{0, 0, 0, 5, 0, 0, 0}, 3);
    for (int r = 0; r < 2; r++) begin
      add('{0, 1, 0, 3, 0, 1, 0}, 3);
      add('{0, 1, 0, 3, 0, 0, 0}, 1);
    end
    add('{0, 0, 0, 3, 0, 0, 0}, 2);
    add('{0, 1, 0, 3, 0, 1, 0}, 1);
    add('{0, 0, 0, 10, 0, 1, 0}, 2);
    add('{0, 0, 0, 10, 0, 0, 0}, 2);
    add('{0, 1, 0, 0, 0, 1, 0}, 1);
    add('{0, 0, 0, 0, 0, 0, 0}, 2);
    add('{0, 1, 0, 5, 0, 1, 0}, 1);
    add('{0, 0, 1, 5, 0, 0, 0}, 1);
    add('{0, 0, 0, 5, 0, 0, 0}, 1);
    add('{0, 1, 0, 3, 0, 1, 0}, 1);
    add('{0, 0, 0, 3, 0, 1, 0}, 2);
    add('{0, 1, 1, 3, 0, 0, 0}, 2);
    add('{0, 0, 0, 3, 0, 0, 0}, 1);
    add('{0, 1, 0, 9, 8, 1, 0}, 1);
    add('{0, 0, 0, 9, 8, 1, 0}, 1);
    add('{1, 0, 0, 9, 8, 0, 0}, 1);
    add('{0, 0, 0, 9, 8, 0, 0}, 1);
    foreach (tbl[i])
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].disp, tbl[i].stop,
           tbl[i].temp, tbl[i].freq, tbl[i].d, tbl[i].a);
    // Freq 8: half 4, toggles every 4 cycles
    step("f8_arm", 0, 1, 0, 100, 8, 1, 0);
    for (int k = 1; k < 16; k++) step("f8_run", 0, 0, 0, 100, 8, 1, 1'((k / 4) % 2));
    step("f8_rest", 0, 0, 0, 100, 0, 1, 0);
    for (int k = 0; k < 6; k++) step("f8_resume", 0, 0, 0, 100, 8, 1, 1'((k / 4) % 2));
    step("f8_stop", 0, 0, 1, 100, 8, 0, 0);
    // Freq 1 clamps half to 1: toggle every cycle
    step("f1_arm", 0, 1, 0, 50, 1, 1, 0);
    for (int k = 1; k < 8; k++) step("f1_run", 0, 0, 0, 50, 1, 1, 1'(k % 2));
    step("f1_stop", 0, 0, 1, 50, 1, 0, 0);
    // Odd Freq 7 truncates to half 3
    step("f7_arm", 0, 1, 0, 50, 7, 1, 0);
    for (int k = 1; k < 9; k++) step("f7_run", 0, 0, 0, 50, 7, 1, 1'((k / 3) % 2));
    step("f7_stop", 0, 0, 1, 50, 7, 0, 0);
    step("idle_after", 0, 0, 0, 50, 7, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
